// File: rtl/pipe_stage_buffer.sv
// Two-entry pipeline stage buffer (main + skid) with per-operand forwarding refresh and flush.
// Optional monitor sidecar compiled only when PIPE_BUF_MON_EN is defined.
module pipe_stage_buffer #(
  parameter int DATA_W   = 128,
  parameter int OPND_W   = 32,
  parameter int NUM_OPND = 2,
  parameter int MON_W    = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [NUM_OPND*OPND_W-1:0] in_opnd,
  input  logic [MON_W-1:0]           in_mon,
  input  logic                       flush,
  input  logic [NUM_OPND-1:0]        fwd_valid,
  input  logic [NUM_OPND*OPND_W-1:0] fwd_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [NUM_OPND*OPND_W-1:0] out_opnd,
  output logic [MON_W-1:0]           out_mon,
  output logic [1:0]                 occupancy
);

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_SKID  = 2'b01;
  localparam logic [1:0] SEL_IN    = 2'b10;
  localparam logic [1:0] SEL_CLEAR = 2'b11;

  logic                       r_main_valid;
  logic [DATA_W-1:0]          r_main_data;
  logic [NUM_OPND*OPND_W-1:0] r_main_opnd;
  logic                       r_skid_valid;
  logic [DATA_W-1:0]          r_skid_data;
  logic [NUM_OPND*OPND_W-1:0] r_skid_opnd;

  logic                       w_accept;
  logic                       w_xfer;
  logic [1:0]                 w_main_sel;
  logic                       w_skid_load;
  logic                       w_skid_valid_nxt;
  logic                       w_main_valid_nxt;
  logic [DATA_W-1:0]          w_main_data_nxt;
  logic [NUM_OPND*OPND_W-1:0] w_main_opnd_nxt;

  assign w_accept = in_valid && !r_skid_valid;
  assign w_xfer   = r_main_valid && out_ready;

  // Decide where main comes from next cycle and whether the skid fills or drains.
  always_comb begin
    w_main_sel       = SEL_HOLD;
    w_skid_load      = 1'b0;
    w_skid_valid_nxt = r_skid_valid;
    if (flush) begin
      w_main_sel       = SEL_CLEAR;
      w_skid_valid_nxt = 1'b0;
    end else if (!r_main_valid || w_xfer) begin
      // Skid valid implies in_ready=0, so no input can race the skid into main.
      if (r_skid_valid) begin
        w_main_sel       = SEL_SKID;
        w_skid_valid_nxt = 1'b0;
      end else if (w_accept) begin
        w_main_sel = SEL_IN;
      end else begin
        w_main_sel = SEL_CLEAR;
      end
    end else begin
      w_main_sel = SEL_HOLD;
      if (w_accept) begin
        w_skid_load      = 1'b1;
        w_skid_valid_nxt = 1'b1;
      end else begin
        w_skid_load = 1'b0;
      end
    end
  end

  // Main entry datapath; a cleared main is zeroed so outputs read zero when idle.
  always_comb begin
    w_main_valid_nxt = r_main_valid;
    w_main_data_nxt  = r_main_data;
    w_main_opnd_nxt  = r_main_opnd;
    case (w_main_sel)
      SEL_SKID: begin
        w_main_valid_nxt = 1'b1;
        w_main_data_nxt  = r_skid_data;
        w_main_opnd_nxt  = r_skid_opnd;
      end
      SEL_IN: begin
        w_main_valid_nxt = 1'b1;
        w_main_data_nxt  = in_data;
        w_main_opnd_nxt  = in_opnd;
      end
      SEL_CLEAR: begin
        w_main_valid_nxt = 1'b0;
        w_main_data_nxt  = '0;
        w_main_opnd_nxt  = '0;
      end
      SEL_HOLD: begin
        for (int i = 0; i < NUM_OPND; i++) begin
          if (fwd_valid[i]) begin
            w_main_opnd_nxt[i*OPND_W +: OPND_W] = fwd_data[i*OPND_W +: OPND_W];
          end else begin
            w_main_opnd_nxt[i*OPND_W +: OPND_W] = r_main_opnd[i*OPND_W +: OPND_W];
          end
        end
      end
      default: begin
        w_main_valid_nxt = 1'b0;
        w_main_data_nxt  = '0;
        w_main_opnd_nxt  = '0;
      end
    endcase
  end

  // Main and skid entry registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_opnd  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_opnd  <= '0;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_main_data  <= w_main_data_nxt;
      r_main_opnd  <= w_main_opnd_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      if (w_skid_load) begin
        r_skid_data <= in_data;
        r_skid_opnd <= in_opnd;
      end else begin
        r_skid_data <= r_skid_data;
        r_skid_opnd <= r_skid_opnd;
      end
    end
  end

`ifdef PIPE_BUF_MON_EN
  localparam logic [MON_W-1:0] MON_NOP = {{(MON_W-32){1'b0}}, 32'h0000_0013};

  logic [MON_W-1:0] r_main_mon;
  logic [MON_W-1:0] r_skid_mon;
  logic [MON_W-1:0] w_main_mon_nxt;

  // Monitor follows its entry; an empty main shows the NOP pattern.
  always_comb begin
    w_main_mon_nxt = r_main_mon;
    case (w_main_sel)
      SEL_SKID:  w_main_mon_nxt = r_skid_mon;
      SEL_IN:    w_main_mon_nxt = in_mon;
      SEL_CLEAR: w_main_mon_nxt = MON_NOP;
      SEL_HOLD:  w_main_mon_nxt = r_main_mon;
      default:   w_main_mon_nxt = MON_NOP;
    endcase
  end

  // Monitor sidecar registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_mon <= MON_NOP;
      r_skid_mon <= '0;
    end else begin
      r_main_mon <= w_main_mon_nxt;
      if (w_skid_load) begin
        r_skid_mon <= in_mon;
      end else begin
        r_skid_mon <= r_skid_mon;
      end
    end
  end

  assign out_mon = r_main_mon;
`else
  logic w_unused_mon;
  assign w_unused_mon = ^in_mon;
  assign out_mon      = '0;
`endif

  assign in_ready  = !r_skid_valid;
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;
  assign out_opnd  = r_main_opnd;
  assign occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Scoreboard bench for pipe_stage_buffer: directed scenarios plus a randomized stream.
module tb_pipe_stage_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [63:0]  in_opnd;
  logic [255:0] in_mon;
  logic         flush;
  logic [1:0]   fwd_valid;
  logic [63:0]  fwd_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [63:0]  out_opnd;
  logic [255:0] out_mon;
  logic [1:0]   occupancy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] data;
    logic [63:0]  opnd;
    logic [255:0] mon;
  } exp_t;
  exp_t sb[$];

`ifdef PIPE_BUF_MON_EN
  localparam logic [255:0] MON_IDLE = 256'h13;
`else
  localparam logic [255:0] MON_IDLE = 256'h0;
`endif

  pipe_stage_buffer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_opnd(in_opnd), .in_mon(in_mon), .flush(flush),
    .fwd_valid(fwd_valid), .fwd_data(fwd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_opnd(out_opnd),
    .out_mon(out_mon), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] exp_mon(input logic [255:0] m);
`ifdef PIPE_BUF_MON_EN
    return m;
`else
    return 256'h0;
`endif
  endfunction

  // Advance one clock while updating the reference model from the handshakes seen before the edge.
  task automatic tick();
    exp_t e;
    if (flush) begin
      sb.delete();
    end else begin
      if (out_valid && !out_ready && sb.size() > 0) begin
        for (int i = 0; i < 2; i++)
          if (fwd_valid[i]) sb[0].opnd[i*32 +: 32] = fwd_data[i*32 +: 32];
      end
      if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
      if (in_valid && in_ready) begin
        e.data = in_data; e.opnd = in_opnd; e.mon = exp_mon(in_mon);
        sb.push_back(e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_data = '0; in_opnd = '0; in_mon = '0;
    flush = 1'b0; fwd_valid = 2'b00; fwd_data = '0; out_ready = 1'b0;
  endtask

  task automatic push(input logic [127:0] d, input logic [63:0] o);
    in_valid = 1'b1; in_data = d; in_opnd = o; in_mon = {d, d};
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0d exp 0", out_valid); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rst_occupancy got %0d exp 0", occupancy); end
    checks++; if (out_data !== 128'h0 || out_opnd !== 64'h0) begin errors++; $display("FAIL rst_out_zero data %h opnd %h exp 0", out_data, out_opnd); end
    checks++; if (out_mon !== MON_IDLE) begin errors++; $display("FAIL rst_out_mon got %h exp %h", out_mon, MON_IDLE); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0d exp 1", in_ready); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    push(128'hA5, 64'h0000_0002_0000_0001);
    checks++; if (out_valid !== 1'b1 || occupancy !== 2'd1) begin errors++; $display("FAIL single_valid valid %0d occ %0d exp 1 1", out_valid, occupancy); end
    checks++; if (sb.size() == 0 || out_data !== sb[0].data) begin errors++; $display("FAIL single_data got %h exp a5", out_data); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 128'h0 || out_opnd !== 64'h0) begin errors++; $display("FAIL single_idle_zero valid %0d data %h opnd %h exp 0", out_valid, out_data, out_opnd); end
    checks++; if (out_mon !== MON_IDLE) begin errors++; $display("FAIL single_idle_mon got %h exp %h", out_mon, MON_IDLE); end
    out_ready = 1'b0;
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    push(128'h11, 64'h0);
    push(128'h22, 64'h0);
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL fill_full occ %0d rdy %0d exp 2 0", occupancy, in_ready); end
    push(128'h33, 64'h0);
    checks++; if (occupancy !== 2'd2 || sb.size() != 2) begin errors++; $display("FAIL fill_refuse occ %0d model %0d exp 2 2", occupancy, sb.size()); end
    out_ready = 1'b1;
    checks++; if (sb.size() == 0 || out_data !== sb[0].data || out_data !== 128'h11) begin errors++; $display("FAIL fill_first got %h exp 11", out_data); end
    tick();
    checks++; if (sb.size() == 0 || out_data !== sb[0].data || out_data !== 128'h22) begin errors++; $display("FAIL fill_second got %h exp 22", out_data); end
    tick();
    checks++; if (occupancy !== 2'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL fill_empty occ %0d rdy %0d exp 0 1", occupancy, in_ready); end
    out_ready = 1'b0;
  endtask

  task automatic test_refresh();
    out_ready = 1'b0;
    push(128'h44, {32'h0000_0ABC, 32'h0000_0100});
    fwd_valid = 2'b01; fwd_data = {32'hDEAD_BEEF, 32'h0000_0200};
    tick();
    fwd_valid = 2'b00;
    checks++; if (out_opnd !== {32'h0000_0ABC, 32'h0000_0200} || out_opnd !== sb[0].opnd) begin errors++; $display("FAIL refresh_op0 got %h exp 00000abc00000200", out_opnd); end
    checks++; if (out_data !== 128'h44) begin errors++; $display("FAIL refresh_data got %h exp 44", out_data); end
    push(128'h45, {32'h0000_0004, 32'h0000_0003});
    fwd_valid = 2'b11; fwd_data = {32'h0000_0009, 32'h0000_0009};
    tick();
    // Refresh during a transfer must not touch the entry moving up from skid.
    fwd_valid = 2'b11; fwd_data = {32'h0000_0007, 32'h0000_0007}; out_ready = 1'b1;
    checks++; if (out_opnd !== {32'h0000_0009, 32'h0000_0009} || out_opnd !== sb[0].opnd) begin errors++; $display("FAIL refresh_both got %h exp 0000000900000009", out_opnd); end
    tick();
    fwd_valid = 2'b00;
    checks++; if (out_data !== 128'h45 || out_opnd !== {32'h0000_0004, 32'h0000_0003}) begin errors++; $display("FAIL refresh_skid_untouched data %h opnd %h exp 45 0000000400000003", out_data, out_opnd); end
    drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    push(128'h51, 64'h1);
    push(128'h52, 64'h2);
    in_valid = 1'b1; in_data = 128'h55; flush = 1'b1; fwd_valid = 2'b11; fwd_data = '1;
    tick();
    in_valid = 1'b0; flush = 1'b0; fwd_valid = 2'b00;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_state valid %0d occ %0d rdy %0d exp 0 0 1", out_valid, occupancy, in_ready); end
    checks++; if (out_data !== 128'h0 || out_opnd !== 64'h0) begin errors++; $display("FAIL flush_zero data %h opnd %h exp 0", out_data, out_opnd); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_input got %0d exp 0", out_valid); end
  endtask

  task automatic test_simul();
    out_ready = 1'b0;
    push(128'h30, 64'h0);
    in_valid = 1'b1; in_data = 128'h33; in_opnd = 64'h0; out_ready = 1'b1;
    checks++; if (out_data !== 128'h30) begin errors++; $display("FAIL simul_first got %h exp 30", out_data); end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (occupancy !== 2'd1 || out_data !== 128'h33 || sb.size() != 1) begin errors++; $display("FAIL simul_main occ %0d data %h exp 1 33", occupancy, out_data); end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 300; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_opnd   = {$urandom, $urandom};
      in_mon    = {8{$urandom}};
      out_ready = ($urandom_range(0, 3) != 0);
      fwd_valid = 2'($urandom_range(0, 3));
      fwd_data  = {$urandom, $urandom};
      #1;
      checks++; if (occupancy !== 2'(sb.size())) begin errors++; $display("FAIL b2b_occ cycle %0d got %0d exp %0d", c, occupancy, sb.size()); end
      if (out_valid) begin
        checks++;
        if (sb.size() == 0 || out_data !== sb[0].data || out_opnd !== sb[0].opnd || out_mon !== sb[0].mon) begin
          errors++; $display("FAIL b2b_entry cycle %0d got %h/%h", c, out_data, out_opnd);
        end
      end else begin
        checks++; if (out_data !== 128'h0 || out_mon !== MON_IDLE) begin errors++; $display("FAIL b2b_idle cycle %0d data %h exp 0", c, out_data); end
      end
      tick();
    end
    idle_inputs();
    drain();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    push(128'h61, 64'h1);
    push(128'h62, 64'h2);
    #3 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 128'h0) begin errors++; $display("FAIL arst_clear valid %0d occ %0d data %h exp 0 0 0", out_valid, occupancy, out_data); end
    checks++; if (out_mon !== MON_IDLE) begin errors++; $display("FAIL arst_mon got %h exp %h", out_mon, MON_IDLE); end
    sb.delete();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    push(128'h77, 64'h5);
    checks++; if (out_valid !== 1'b1 || out_data !== 128'h77 || occupancy !== 2'd1) begin errors++; $display("FAIL arst_first valid %0d data %h occ %0d exp 1 77 1", out_valid, out_data, occupancy); end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_refresh();
    test_flush();
    test_simul();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
